// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-wide memory port controller.
package mem_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam logic [1:0] IO_PREFIX = 2'b11;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_LSB = 1'b1
  } grant_e;

  // Width code 3 is not a legal access size and falls back to a full word.
  function automatic logic [2:0] width_to_bytes(input logic [1:0] width);
    logic [2:0] n;
    case (width)
      WIDTH_BYTE: n = 3'd1;
      WIDTH_HALF: n = 3'd2;
      WIDTH_WORD: n = 3'd4;
      default:    n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter between instruction fetch and the load/store buffer.
module mem_rr_arbiter
  import mem_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hold_en_i,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic lsb_req_i,
  input  logic lsb_stall_i,
  output logic if_gnt_o,
  output logic lsb_gnt_o
);

  grant_e last_grant_q;
  grant_e last_grant_d;
  logic   lsb_ok_s;

  assign lsb_ok_s = lsb_req_i & ~lsb_stall_i;

  // Grant selection: a tie goes to whichever side was not served last.
  always_comb begin
    if_gnt_o     = 1'b0;
    lsb_gnt_o    = 1'b0;
    last_grant_d = last_grant_q;
    if (!arb_en_i) begin
      if_gnt_o  = 1'b0;
      lsb_gnt_o = 1'b0;
    end else if (if_req_i && lsb_ok_s) begin
      if (last_grant_q == GRANT_IF) begin
        lsb_gnt_o = 1'b1;
      end else begin
        if_gnt_o = 1'b1;
      end
    end else if (if_req_i) begin
      if_gnt_o = 1'b1;
    end else if (lsb_ok_s) begin
      lsb_gnt_o = 1'b1;
    end else begin
      if_gnt_o  = 1'b0;
      lsb_gnt_o = 1'b0;
    end

    if (if_gnt_o) begin
      last_grant_d = GRANT_IF;
    end else if (lsb_gnt_o) begin
      last_grant_d = GRANT_LSB;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Remember the last winner; frozen while the core is not ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= GRANT_IF;
    end else if (hold_en_i) begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO port controller: arbitrates IF and LSB, sequences byte
// cycles and reassembles little-endian read data into one reply per access.
module mem_ctrl
  import mem_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_signal,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  if_query_en,
  input  logic [ADDR_WIDTH-1:0] if_query_addr,
  output logic                  if_reply_en,
  output logic [31:0]           if_reply_data,
  input  logic                  lsb_query_en,
  input  logic                  lsb_query_type,
  input  logic [ADDR_WIDTH-1:0] lsb_query_addr,
  input  logic [1:0]            lsb_data_width,
  input  logic [31:0]           lsb_query_data,
  output logic                  lsb_reply_en,
  output logic [31:0]           lsb_reply_data
);

  state_e                  state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic [2:0]              nbytes_q, nbytes_d;
  logic                    is_lsb_q, is_lsb_d;
  logic                    flushed_q, flushed_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   mem_a_q, mem_a_d;
  logic [7:0]              mem_dout_q, mem_dout_d;
  logic                    wr_q, wr_d;
  logic                    if_reply_en_q, if_reply_en_d;
  logic [31:0]             if_reply_data_q, if_reply_data_d;
  logic                    lsb_reply_en_q, lsb_reply_en_d;
  logic [31:0]             lsb_reply_data_q, lsb_reply_data_d;

  logic                    arb_en_s;
  logic                    lsb_stall_s;
  logic                    if_gnt_s;
  logic                    lsb_gnt_s;

  assign arb_en_s    = (state_q == IDLE) & ~flush_signal;
  assign lsb_stall_s = lsb_query_type & io_buffer_full &
                       (lsb_query_addr[17:16] == IO_PREFIX);

  mem_rr_arbiter u_arb (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .hold_en_i   (rdy_in),
    .arb_en_i    (arb_en_s),
    .if_req_i    (if_query_en),
    .lsb_req_i   (lsb_query_en),
    .lsb_stall_i (lsb_stall_s),
    .if_gnt_o    (if_gnt_s),
    .lsb_gnt_o   (lsb_gnt_s)
  );

  // Byte sequencer: next state, address/data stepping and reply generation.
  always_comb begin
    state_d          = state_q;
    step_d           = step_q;
    nbytes_d         = nbytes_q;
    is_lsb_d         = is_lsb_q;
    flushed_d        = flushed_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    mem_a_d          = mem_a_q;
    mem_dout_d       = mem_dout_q;
    wr_d             = 1'b0;
    if_reply_en_d    = 1'b0;
    if_reply_data_d  = if_reply_data_q;
    lsb_reply_en_d   = 1'b0;
    lsb_reply_data_d = lsb_reply_data_q;

    case (state_q)
      IDLE: begin
        if (if_gnt_s || lsb_gnt_s) begin
          step_d    = 3'd0;
          flushed_d = 1'b0;
          rdata_d   = 32'd0;
          is_lsb_d  = lsb_gnt_s;
          if (if_gnt_s) begin
            nbytes_d = 3'd4;
            mem_a_d  = if_query_addr;
          end else begin
            nbytes_d = width_to_bytes(lsb_data_width);
            mem_a_d  = lsb_query_addr;
          end
          if (lsb_gnt_s && lsb_query_type) begin
            state_d    = WRITE;
            wdata_d    = lsb_query_data;
            mem_dout_d = lsb_query_data[7:0];
            wr_d       = 1'b1;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end

      READ: begin
        if (flush_signal) begin
          state_d = DONE;
        end else begin
          // mem_din carries the byte addressed one cycle earlier.
          case (step_q)
            3'd1:    rdata_d[7:0]   = mem_din;
            3'd2:    rdata_d[15:8]  = mem_din;
            3'd3:    rdata_d[23:16] = mem_din;
            3'd4:    rdata_d[31:24] = mem_din;
            default: rdata_d        = rdata_q;
          endcase
          if (step_q == nbytes_q) begin
            state_d = DONE;
            if (is_lsb_q) begin
              lsb_reply_en_d   = 1'b1;
              lsb_reply_data_d = rdata_d;
            end else begin
              if_reply_en_d   = 1'b1;
              if_reply_data_d = rdata_d;
            end
          end else begin
            if (step_q < (nbytes_q - 3'd1)) begin
              mem_a_d = mem_a_q + 32'd1;
            end else begin
              mem_a_d = mem_a_q;
            end
            step_d = step_q + 3'd1;
          end
        end
      end

      WRITE: begin
        // A flush cannot cancel a store already on the bus, only its reply.
        flushed_d = flushed_q | flush_signal;
        if (step_q == (nbytes_q - 3'd1)) begin
          state_d = DONE;
          wr_d    = 1'b0;
          if (!(flushed_q || flush_signal)) begin
            lsb_reply_en_d   = 1'b1;
            lsb_reply_data_d = 32'd0;
          end else begin
            lsb_reply_en_d = 1'b0;
          end
        end else begin
          mem_a_d    = mem_a_q + 32'd1;
          mem_dout_d = wdata_q[15:8];
          wdata_d    = {8'd0, wdata_q[31:8]};
          wr_d       = 1'b1;
          step_d     = step_q + 3'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q          <= IDLE;
      step_q           <= 3'd0;
      nbytes_q         <= 3'd0;
      is_lsb_q         <= 1'b0;
      flushed_q        <= 1'b0;
      wdata_q          <= 32'd0;
      rdata_q          <= 32'd0;
      mem_a_q          <= 32'd0;
      mem_dout_q       <= 8'd0;
      wr_q             <= 1'b0;
      if_reply_en_q    <= 1'b0;
      if_reply_data_q  <= 32'd0;
      lsb_reply_en_q   <= 1'b0;
      lsb_reply_data_q <= 32'd0;
    end else if (rdy_in) begin
      state_q          <= state_d;
      step_q           <= step_d;
      nbytes_q         <= nbytes_d;
      is_lsb_q         <= is_lsb_d;
      flushed_q        <= flushed_d;
      wdata_q          <= wdata_d;
      rdata_q          <= rdata_d;
      mem_a_q          <= mem_a_d;
      mem_dout_q       <= mem_dout_d;
      wr_q             <= wr_d;
      if_reply_en_q    <= if_reply_en_d;
      if_reply_data_q  <= if_reply_data_d;
      lsb_reply_en_q   <= lsb_reply_en_d;
      lsb_reply_data_q <= lsb_reply_data_d;
    end
  end

  assign mem_a          = mem_a_q;
  assign mem_dout       = mem_dout_q;
  assign mem_wr         = wr_q & rdy_in;
  assign if_reply_en    = if_reply_en_q;
  assign if_reply_data  = if_reply_data_q;
  assign lsb_reply_en   = lsb_reply_en_q;
  assign lsb_reply_data = lsb_reply_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model and reply scoreboards.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_signal;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_query_en;
  logic [31:0] if_query_addr;
  logic        if_reply_en;
  logic [31:0] if_reply_data;
  logic        lsb_query_en;
  logic        lsb_query_type;
  logic [31:0] lsb_query_addr;
  logic [1:0]  lsb_data_width;
  logic [31:0] lsb_query_data;
  logic        lsb_reply_en;
  logic [31:0] lsb_reply_data;

  int checks = 0;
  int failures = 0;
  int if_replies = 0;
  int lsb_replies = 0;

  logic [31:0] if_exp[$];
  logic [31:0] lsb_exp[$];
  logic [7:0]  ram [0:65535];

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush_signal   (flush_signal),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .if_query_en    (if_query_en),
    .if_query_addr  (if_query_addr),
    .if_reply_en    (if_reply_en),
    .if_reply_data  (if_reply_data),
    .lsb_query_en   (lsb_query_en),
    .lsb_query_type (lsb_query_type),
    .lsb_query_addr (lsb_query_addr),
    .lsb_data_width (lsb_data_width),
    .lsb_query_data (lsb_query_data),
    .lsb_reply_en   (lsb_reply_en),
    .lsb_reply_data (lsb_reply_data)
  );

  always #5 clk_in = ~clk_in;

  // RAM: one-cycle read latency, writes on the edge that sees mem_wr.
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) ram[mem_a[15:0]] = mem_dout;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_reply(input bit is_lsb, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (is_lsb ? lsb_reply_en : if_reply_en) break;
      tick();
    end
    check(is_lsb ? "lsb_reply_seen" : "if_reply_seen",
          is_lsb ? lsb_reply_en : if_reply_en, 1'b1);
  endtask

  task automatic set_lsb(input logic en, input logic typ, input logic [31:0] addr,
                         input logic [1:0] width, input logic [31:0] data);
    lsb_query_en   = en;
    lsb_query_type = typ;
    lsb_query_addr = addr;
    lsb_data_width = width;
    lsb_query_data = data;
  endtask

  // Scoreboard: every reply cycle pops and compares one expected word.
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (if_reply_en) begin
        if_replies++;
        if (if_exp.size() == 0) check("if_unexpected_reply", 1'b1, 1'b0);
        else check("if_reply_data", if_reply_data, if_exp.pop_front());
      end
      if (lsb_reply_en) begin
        lsb_replies++;
        if (lsb_exp.size() == 0) check("lsb_unexpected_reply", 1'b1, 1'b0);
        else check("lsb_reply_data", lsb_reply_data, lsb_exp.pop_front());
      end
      if (if_reply_en && lsb_reply_en) check("replies_exclusive", 1'b1, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int lsb_before;
    bit any_wr;
    bit saw_if;

    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
    ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22; ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;
    ram[16'h0040] = 8'hA7; ram[16'h0041] = 8'h5C;

    rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0; io_buffer_full = 1'b0;
    if_query_en = 1'b0; if_query_addr = 32'h0;
    set_lsb(1'b0, 1'b0, 32'h0, 2'd0, 32'h0);

    // Reset state
    tick(); tick();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_dout", mem_dout, 8'h0);
    check("rst_replies", {if_reply_en, lsb_reply_en}, 2'b00);
    rst_in = 1'b1;
    tick();

    // IF word read at 0x100
    if_exp.push_back(32'h0000_0513);
    if_query_en = 1'b1; if_query_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("if_read_addr", mem_a, 32'h100 + 32'(i));
    end
    tick();
    check("if_reply_not_early", if_reply_en, 1'b0);
    tick();
    check("if_reply_cycle5", if_reply_en, 1'b1);
    if_query_en = 1'b0;
    tick();

    // Halfword store 0xBEEF to 0x2002, request held through DONE
    lsb_exp.push_back(32'h0);
    set_lsb(1'b1, 1'b1, 32'h2002, 2'd1, 32'h0000_BEEF);
    tick();
    check("sh_b0", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2002, 8'hEF});
    tick();
    check("sh_b1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h2003, 8'hBE});
    tick();
    check("sh_reply", {mem_wr, lsb_reply_en}, 2'b01);
    tick();
    check("sh_done_no_regrant", mem_wr, 1'b0);
    lsb_query_en = 1'b0;
    check("sh_ram", {ram[16'h2003], ram[16'h2002]}, 16'hBEEF);
    tick();

    // Reset in the middle of a read: outputs clear without a clock edge
    if_query_en = 1'b1; if_query_addr = 32'h100;
    tick(); tick(); tick();
    #2;
    rst_in = 1'b0;
    #1;
    check("async_rst_mem_a", mem_a, 32'h0);
    check("async_rst_outputs", {mem_wr, mem_dout, if_reply_en, lsb_reply_en}, 11'h0);
    if_query_en = 1'b0;
    tick(); tick();
    rst_in = 1'b1;
    tick();

    // Tie from reset goes to LSB, then IF, then LSB again
    lsb_exp.push_back(32'h0000_00A7);
    if_exp.push_back(32'h4433_2211);
    set_lsb(1'b1, 1'b0, 32'h40, 2'd0, 32'h0);
    if_query_en = 1'b1; if_query_addr = 32'h200;
    tick();
    check("tie1_lsb_first", mem_a, 32'h40);
    wait_reply(1'b1, 10);
    lsb_query_en = 1'b0;
    tick(); tick();
    check("tie1_if_second", mem_a, 32'h200);
    wait_reply(1'b0, 10);
    if_query_en = 1'b0;
    tick();
    lsb_exp.push_back(32'h0000_005C);
    if_exp.push_back(32'h4433_2211);
    set_lsb(1'b1, 1'b0, 32'h41, 2'd0, 32'h0);
    if_query_en = 1'b1;
    tick();
    check("tie2_lsb_first", mem_a, 32'h41);
    wait_reply(1'b1, 10);
    lsb_query_en = 1'b0;
    wait_reply(1'b0, 12);
    if_query_en = 1'b0;
    tick(); tick();

    // IO store stalls while the UART buffer is full; IF is served meanwhile
    lsb_exp.push_back(32'h0);
    if_exp.push_back(32'h0000_0513);
    io_buffer_full = 1'b1;
    set_lsb(1'b1, 1'b1, 32'h0003_0000, 2'd0, 32'h0000_0041);
    if_query_en = 1'b1; if_query_addr = 32'h100;
    any_wr = 1'b0; saw_if = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_wr) any_wr = 1'b1;
      if (if_reply_en) begin
        saw_if = 1'b1;
        if_query_en = 1'b0;
      end
    end
    check("io_stall_no_write", any_wr, 1'b0);
    check("io_stall_if_served", saw_if, 1'b1);
    io_buffer_full = 1'b0;
    tick();
    check("io_write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0003_0000, 8'h41});
    wait_reply(1'b1, 5);
    lsb_query_en = 1'b0;
    tick(); tick();

    // Flush in cycle 2 of a word load: no reply, one DONE cycle
    lsb_before = lsb_replies;
    set_lsb(1'b1, 1'b0, 32'h200, 2'd2, 32'h0);
    tick(); tick(); tick();
    flush_signal = 1'b1;
    tick();
    flush_signal = 1'b0;
    lsb_query_en = 1'b0;
    tick();
    // Flush in cycle 1 of a word store: every byte still lands, no reply
    set_lsb(1'b1, 1'b1, 32'h400, 2'd2, 32'hCAFE_F00D);
    tick();
    check("sw_after_flush_granted", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h400, 8'h0D});
    tick();
    flush_signal = 1'b1;
    tick();
    flush_signal = 1'b0;
    tick();
    check("sw_flush_last_byte", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h403, 8'hCA});
    tick();
    check("sw_flush_no_reply", {mem_wr, lsb_reply_en}, 2'b00);
    lsb_query_en = 1'b0;
    tick(); tick();
    check("sw_flush_ram", {ram[16'h0403], ram[16'h0402], ram[16'h0401], ram[16'h0400]}, 32'hCAFE_F00D);
    check("flush_reply_count", lsb_replies, lsb_before);

    // Freeze mid-store: bus held, write resumes at the same byte
    lsb_exp.push_back(32'h0);
    set_lsb(1'b1, 1'b1, 32'h500, 2'd2, 32'h8765_4321);
    tick();
    tick();
    check("frz_pre", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h501, 8'h43});
    rdy_in = 1'b0;
    #1;
    check("frz_wr_gated", mem_wr, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_hold", {mem_wr, mem_a}, {1'b0, 32'h501});
    end
    rdy_in = 1'b1;
    #1;
    check("frz_resume", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h501, 8'h43});
    wait_reply(1'b1, 8);
    lsb_query_en = 1'b0;
    tick(); tick();
    check("frz_ram", {ram[16'h0503], ram[16'h0502], ram[16'h0501], ram[16'h0500]}, 32'h8765_4321);
    check("scoreboard_drained", if_exp.size() + lsb_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
